clock_set_ctrl: RTL

- Sequences the time-setting datapath: owns the edit/run state machine and the per-field edit registers (hours, minutes, seconds), applies wrap-around increment/decrement, and commits the edited time to the timekeeper through a valid/ready load handshake.
- Sits between the debounced buttons/switches and the timekeeper.
- Drives the timekeeper count enable and field-select code, plus a blink strobe for the 7-segment driver.

---
 rtl/clock_set_pkg.sv | 27 ++
 rtl/clock_set_ctrl_time_field_step.sv | 22 ++
 rtl/clock_set_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/clock_set_pkg.sv
// Shared types and limits for the time-setting controller.
// Field codes match the mode encoding the timekeeper already uses.
package clock_set_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEC,
        ST_MIN,
        ST_HRS,
        ST_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_SEC  = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_HRS  = 2'd3
    } field_t;

    localparam int HRS_W = 5;
    localparam int MS_W  = 6;

    localparam logic [MS_W-1:0]  MAX_SEC = 6'd59;
    localparam logic [MS_W-1:0]  MAX_MIN = 6'd59;
    localparam logic [HRS_W-1:0] MAX_HRS = 5'd23;

endpackage

// File: rtl/clock_set_ctrl_time_field_step.sv
// Wrap-around increment/decrement of a single time field.
// Holds the value when neither or both of inc/dec are set.
module time_field_step
    import clock_set_pkg::*;
(
    input  logic [MS_W-1:0] value,
    input  logic [MS_W-1:0] max_value,
    input  logic            inc,
    input  logic            dec,
    output logic [MS_W-1:0] result
);

    always_comb begin
        result = value;
        if (inc && !dec) begin
            result = (value >= max_value) ? '0 : value + 1'b1;
        end else if (dec && !inc) begin
            result = (value == '0) ? max_value : value - 1'b1;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Edit/run sequencer for the clock: field editing, blink strobe, edit timeout
// and the valid/ready load handshake into the timekeeper.
//
// state     | meaning
// ST_IDLE   | clock running, waiting for an edit_en rising edge
// ST_SEC    | editing seconds
// ST_MIN    | editing minutes
// ST_HRS    | editing hours
// ST_COMMIT | load_valid high until the timekeeper accepts the edit
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int BLINK_DIV      = 25000000,
    parameter int TIMEOUT_BLINKS = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             edit_en,
    input  logic             btn_next,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic [HRS_W-1:0] cur_hrs,
    input  logic [MS_W-1:0]  cur_min,
    input  logic [MS_W-1:0]  cur_sec,
    input  logic             load_ready,
    output logic             load_valid,
    output logic [HRS_W-1:0] load_hrs,
    output logic [MS_W-1:0]  load_min,
    output logic [MS_W-1:0]  load_sec,
    output logic             run_en,
    output logic [1:0]       field,
    output logic             blink
);

    localparam int CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDLE_W = (TIMEOUT_BLINKS > 1) ? $clog2(TIMEOUT_BLINKS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BLINK_DIV - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_BLINKS - 1);

    state_t             state, state_n;
    logic               edit_q;
    logic               edit_rise, edit_fall;
    logic               in_edit, next_in_edit;
    logic               any_btn, timeout, field_write;
    logic [HRS_W-1:0]   reg_hrs;
    logic [MS_W-1:0]    reg_min, reg_sec;
    logic [CNT_W-1:0]   blink_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [MS_W-1:0]    sel_val, sel_max, step_out;

    assign edit_rise = edit_en && !edit_q;
    assign edit_fall = !edit_en && edit_q;
    assign in_edit   = (state == ST_SEC) || (state == ST_MIN) || (state == ST_HRS);
    assign next_in_edit = (state_n == ST_SEC) || (state_n == ST_MIN) || (state_n == ST_HRS);
    assign any_btn   = btn_next || btn_inc || btn_dec;
    // Abort fires on the blink wrap that would complete the last quiet half-period.
    assign timeout   = in_edit && (blink_cnt == CNT_LAST) && (idle_cnt == IDLE_LAST);
    assign field_write = in_edit && !edit_fall && !timeout && !btn_next && (btn_inc || btn_dec);

    assign load_valid = (state == ST_COMMIT);
    assign run_en     = (state == ST_IDLE);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (edit_rise) state_n = ST_SEC;
            ST_SEC, ST_MIN, ST_HRS: begin
                if (edit_fall) begin
                    state_n = ST_COMMIT;
                end else if (timeout) begin
                    state_n = ST_IDLE;
                end else if (btn_next) begin
                    state_n = (state == ST_SEC) ? ST_MIN :
                              (state == ST_MIN) ? ST_HRS : ST_SEC;
                end
            end
            ST_COMMIT: if (load_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        field   = FIELD_NONE;
        sel_val = '0;
        sel_max = '0;
        case (state)
            ST_SEC: begin field = FIELD_SEC; sel_val = reg_sec;          sel_max = MAX_SEC;          end
            ST_MIN: begin field = FIELD_MIN; sel_val = reg_min;          sel_max = MAX_MIN;          end
            ST_HRS: begin field = FIELD_HRS; sel_val = {1'b0, reg_hrs};  sel_max = {1'b0, MAX_HRS};  end
            default: ;
        endcase
    end

    time_field_step u_step (
        .value     (sel_val),
        .max_value (sel_max),
        .inc       (btn_inc),
        .dec       (btn_dec),
        .result    (step_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            edit_q    <= 1'b0;
            reg_hrs   <= '0;
            reg_min   <= '0;
            reg_sec   <= '0;
            load_hrs  <= '0;
            load_min  <= '0;
            load_sec  <= '0;
            blink_cnt <= '0;
            idle_cnt  <= '0;
            blink     <= 1'b0;
        end else begin
            state  <= state_n;
            edit_q <= edit_en;

            if (state == ST_IDLE && state_n == ST_SEC) begin
                reg_hrs <= (cur_hrs > MAX_HRS) ? MAX_HRS : cur_hrs;
                reg_min <= (cur_min > MAX_MIN) ? MAX_MIN : cur_min;
                reg_sec <= (cur_sec > MAX_SEC) ? MAX_SEC : cur_sec;
            end else if (field_write) begin
                case (state)
                    ST_SEC:  reg_sec <= step_out;
                    ST_MIN:  reg_min <= step_out;
                    ST_HRS:  reg_hrs <= step_out[HRS_W-1:0];
                    default: ;
                endcase
            end

            if (state != ST_COMMIT && state_n == ST_COMMIT) begin
                load_hrs <= reg_hrs;
                load_min <= reg_min;
                load_sec <= reg_sec;
            end

            if (!next_in_edit) begin
                blink_cnt <= '0;
                idle_cnt  <= '0;
                blink     <= 1'b0;
            end else if (state != state_n || any_btn) begin
                blink_cnt <= '0;
                idle_cnt  <= '0;
                blink     <= 1'b1;
            end else if (blink_cnt == CNT_LAST) begin
                blink_cnt <= '0;
                idle_cnt  <= idle_cnt + 1'b1;
                blink     <= !blink;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

endmodule
